sar_search_ctrl: RTL and testbench

- Sequential initiator for the 2-bit magnitude-compare protocol. Block drives a trial value `guess` into an external combinational comparator and consumes its 2-bit verdict `cmp_res`.
- Uses successive approximation, MSB first, to find an unknown W-bit target held on the comparator's other operand.
- Used by datapath test harnesses and by search-style instructions that need an operand recovered through compare-only access.

---
 rtl/sar_search_ctrl_if.sv | 24 ++
 rtl/sar_search_ctrl.sv | 113 +++++++++++
 tb/tb_sar_search_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// Compare-protocol bundle between the SAR search controller and its requester/comparator side.
// master = controller (drives guess and status), slave = environment (drives start and verdict).
interface sar_search_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic [1:0]   cmp_res;
  logic [W-1:0] guess;
  logic         busy;
  logic         done;
  logic [W-1:0] found;
  logic [3:0]   probes;
  logic         err;

  modport master (
    input  start, cmp_res,
    output guess, busy, done, found, probes, err
  );

  modport slave (
    output start, cmp_res,
    input  guess, busy, done, found, probes, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: recovers a W-bit target, MSB first,
// through a 2-bit magnitude comparator (00 equal, 01 guess>target, 10 guess<target).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; guess/found/probes/err held; done pulses once after a search
// ST_PROBE | one comparator verdict consumed per cycle, bit idx decided per verdict
module sar_search_ctrl #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             reset,
  sar_search_ctrl_if.master bus
);

  localparam int IW = (W > 2) ? $clog2(W) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PROBE = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] guess_q;
  logic [W-1:0] found_q;
  logic [3:0]   probes_q;
  logic         done_q;
  logic         err_q;
  logic [IW-1:0] idx;

  logic [W-1:0] bit_cur;
  logic [W-1:0] bit_low;
  logic [W-1:0] guess_clr;
  logic [3:0]   probes_inc;
  logic         idx_zero;

  always_comb begin
    bit_cur = '0;
    bit_low = '0;
    bit_cur[idx] = 1'b1;
    if (idx != '0) bit_low[idx - 1'b1] = 1'b1;
    guess_clr  = guess_q & ~bit_cur;
    idx_zero   = (idx == '0);
    // saturation is only a safety net; a legal search never passes W probes
    probes_inc = (probes_q == 4'd15) ? 4'd15 : probes_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      guess_q  <= '0;
      found_q  <= '0;
      probes_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      idx      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            guess_q  <= {1'b1, {(W-1){1'b0}}};
            idx      <= IW'(W-1);
            probes_q <= '0;
            err_q    <= 1'b0;
            state    <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          probes_q <= probes_inc;
          case (bus.cmp_res)
            2'b00: begin
              found_q <= guess_q;
              done_q  <= 1'b1;
              state   <= ST_IDLE;
            end
            2'b01: begin
              if (idx_zero) begin
                found_q <= guess_clr;
                done_q  <= 1'b1;
                state   <= ST_IDLE;
              end else begin
                guess_q <= guess_clr | bit_low;
                idx     <= idx - 1'b1;
              end
            end
            2'b10: begin
              // guess still too small with every bit decided: no target fits
              if (idx_zero) begin
                err_q <= 1'b1;
                state <= ST_IDLE;
              end else begin
                guess_q <= guess_q | bit_low;
                idx     <= idx - 1'b1;
              end
            end
            default: begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state == ST_PROBE);
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.probes = probes_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomized bench for sar_search_ctrl with an arithmetic reference for guess sequence,
// probe count and result, plus directed corner cases (faulty verdicts, held start, mid-search reset).
module tb_sar_search_ctrl;
  localparam int W = 4;

  logic clk;
  logic reset;
  logic [W-1:0] target;
  int force_mode;   // 0: honest comparator, 1: always 10, 2: always 11
  int n_checks;
  int n_fail;
  logic [W-1:0] prev_found;

  sar_search_ctrl_if #(.W(W)) bus ();

  sar_search_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (force_mode == 1)            bus.cmp_res = 2'b10;
    else if (force_mode == 2)       bus.cmp_res = 2'b11;
    else if (bus.guess == target)   bus.cmp_res = 2'b00;
    else if (bus.guess > target)    bus.cmp_res = 2'b01;
    else                            bus.cmp_res = 2'b10;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // k-th trial value: top k-1 bits already equal the target, next bit set, rest clear
  function automatic logic [W-1:0] exp_guess(input logic [W-1:0] t, input int k);
    logic [W-1:0] m;
    logic [W-1:0] one;
    m = '0;
    for (int i = 0; i < W; i++)
      if (i >= W - (k - 1)) m[i] = 1'b1;
    one = '0;
    one[W-k] = 1'b1;
    return (t & m) | one;
  endfunction

  // an honest search stops at the target's lowest set bit
  function automatic int exp_probe_count(input logic [W-1:0] t);
    int tz;
    if (t == '0) return W;
    tz = 0;
    while (t[tz] == 1'b0) tz++;
    return W - tz;
  endfunction

  // Entered at a negedge where the first probe cycle is expected; leaves at the
  // negedge after the deciding probe, having checked the outcome.
  task automatic run_probes(input logic [W-1:0] tgt, input int mode);
    int k;
    int exp_n;
    logic [W-1:0] eff;
    logic exp_err;
    logic exp_done;
    logic [W-1:0] exp_found;
    eff = (mode == 1) ? {W{1'b1}} : tgt;
    exp_n = (mode == 0) ? exp_probe_count(tgt) : (mode == 1) ? W : 1;
    exp_err  = (mode != 0);
    exp_done = (mode == 0);
    exp_found = (mode == 0) ? tgt : prev_found;
    k = 0;
    chk("busy_enter", {31'b0, bus.busy}, 32'd1);
    while (bus.busy) begin
      k++;
      if (k > W + 1) begin
        chk("probe_budget", k, W + 1);
        break;
      end
      chk("guess", bus.guess, exp_guess(eff, k));
      chk("probes_run", bus.probes, k - 1);
      chk("found_hold", bus.found, prev_found);
      chk("done_low", {31'b0, bus.done}, 32'd0);
      @(negedge clk);
    end
    chk("probe_cnt", k, exp_n);
    chk("probes_out", bus.probes, exp_n);
    chk("done_pulse", {31'b0, bus.done}, {31'b0, exp_done});
    chk("err", {31'b0, bus.err}, {31'b0, exp_err});
    chk("found", bus.found, exp_found);
    prev_found = exp_found;
  endtask

  task automatic do_search(input logic [W-1:0] tgt, input int mode);
    logic exp_err;
    exp_err = (mode != 0);
    target = tgt;
    force_mode = mode;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_probes(tgt, mode);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, bus.done}, 32'd0);
    chk("idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("err_sticky", {31'b0, bus.err}, {31'b0, exp_err});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_guess"},  bus.guess,  32'd0);
    chk({tag, "_found"},  bus.found,  32'd0);
    chk({tag, "_probes"}, bus.probes, 32'd0);
    chk({tag, "_busy"},   {31'b0, bus.busy}, 32'd0);
    chk({tag, "_done"},   {31'b0, bus.done}, 32'd0);
    chk({tag, "_err"},    {31'b0, bus.err},  32'd0);
  endtask

  initial begin
    int r;
    n_checks = 0;
    n_fail = 0;
    prev_found = '0;
    force_mode = 0;
    target = '0;
    bus.start = 1'b0;
    reset = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    do_search(4'b1010, 0);
    do_search(4'b0000, 0);
    do_search(4'b1111, 0);
    do_search(4'b1000, 0);
    do_search(4'b0110, 1);
    do_search(4'b0110, 2);

    // start held high: no restart mid-search, restart accepted in the done cycle
    target = 4'b1010;
    force_mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("held_err_clr", {31'b0, bus.err}, 32'd0);
    run_probes(4'b1010, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_busy", {31'b0, bus.busy}, 32'd1);
    chk("restart_done", {31'b0, bus.done}, 32'd0);
    chk("restart_found", bus.found, 32'hA);
    target = 4'b0110;
    run_probes(4'b0110, 0);
    @(negedge clk);

    // reset during the second probe of a 1010 search
    target = 4'b1010;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_guess", bus.guess, 32'hC);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    prev_found = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", {31'b0, bus.done}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    do_search(4'b1010, 0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      do_search(4'($urandom_range(0, 15)), (r < 7) ? 0 : (r < 9) ? 1 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
